writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 161 ++++++++++++++++
 tb/tb_writeback_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Final pipeline stage. Captures one instruction per cycle from the upstream
// stage, selects the writeback value (ALU result, extracted load data or link
// address) and presents registered write ports for the GPR file and the HI/LO
// pair. Also counts retired instructions.
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-low reset
//   in_valid    upstream presents an instruction this cycle
//   stall       hold the output register; no new capture
//   flush       discard captured and presented instruction (wins over stall)
//   alu_rslt    2*XLEN ALU / mul-div result
//   mem_rdata   raw aligned memory word
//   mem_off     byte offset of the load address
//   ld_mode     load extraction mode (word / half s,u / byte s,u)
//   pc          instruction PC (link writes use pc + 4)
//   wd_sel      writeback source: 00 ALU, 01 MEM, 10 link, 11 reserved
//   rdst_in     destination register
//   rfwr_in     GPR write requested
//   mdiv_in     result targets HI/LO
//   rf_we, rf_waddr, rf_wdata     registered GPR write port
//   hilo_we, hi_wdata, lo_wdata   registered HI/LO write port
//   wb_valid    output register holds a live instruction
//   retire_cnt  wrapping count of retired instructions
// -----------------------------------------------------------------------------
module writeback_unit #(
   parameter int XLEN     = 32,
   parameter int RADDR_W  = 5,
   parameter int LINK_REG = 31,
   parameter int HILO_EN  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [2*XLEN-1:0]    alu_rslt,
   input  logic [XLEN-1:0]      mem_rdata,
   input  logic [1:0]           mem_off,
   input  logic [2:0]           ld_mode,
   input  logic [XLEN-1:0]      pc,
   input  logic [1:0]           wd_sel,
   input  logic [RADDR_W-1:0]   rdst_in,
   input  logic                 rfwr_in,
   input  logic                 mdiv_in,
   output logic                 rf_we,
   output logic [RADDR_W-1:0]   rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic                 hilo_we,
   output logic [XLEN-1:0]      hi_wdata,
   output logic [XLEN-1:0]      lo_wdata,
   output logic                 wb_valid,
   output logic [31:0]          retire_cnt
);

   localparam logic [1:0] WD_ALU  = 2'b00;
   localparam logic [1:0] WD_MEM  = 2'b01;
   localparam logic [1:0] WD_LINK = 2'b10;
   localparam logic [1:0] WD_RSVD = 2'b11;

   localparam logic [2:0] LD_HS = 3'b001;
   localparam logic [2:0] LD_HU = 3'b010;
   localparam logic [2:0] LD_BS = 3'b011;
   localparam logic [2:0] LD_BU = 3'b100;

   localparam logic               HILO_ON   = (HILO_EN != 0);
   localparam logic [RADDR_W-1:0] LINK_ADDR = RADDR_W'(LINK_REG);
   localparam logic [XLEN-1:0]    PC_STEP   = XLEN'(4);

   // ---------------------------------------------------------------------------
   // Load extraction: shift the addressed lane down to bit 0, then extend.
   // Halfword loads use only mem_off[1]; mem_off[0] is ignored.
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] byte_shift;
   logic [XLEN-1:0] half_shift;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] ld_value;

   assign byte_shift = mem_rdata >> {mem_off, 3'b000};
   assign half_shift = mem_rdata >> {mem_off[1], 4'b0000};
   assign byte_sel   = byte_shift[7:0];
   assign half_sel   = half_shift[15:0];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      ld_value = mem_rdata;
      case (ld_mode)
         LD_HS:   ld_value = {{(XLEN-16){half_sel[15]}}, half_sel};
         LD_HU:   ld_value = {{(XLEN-16){1'b0}},         half_sel};
         LD_BS:   ld_value = {{(XLEN-8){byte_sel[7]}},   byte_sel};
         LD_BU:   ld_value = {{(XLEN-8){1'b0}},          byte_sel};
         default: ld_value = mem_rdata;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state values for the output register.
   // ---------------------------------------------------------------------------
   logic [RADDR_W-1:0] waddr_d;
   logic [XLEN-1:0]    wdata_d;
   logic               rf_we_d;
   logic               hilo_we_d;

   always_comb begin
      waddr_d = rdst_in;
      wdata_d = alu_rslt[XLEN-1:0];
      case (wd_sel)
         WD_MEM:  wdata_d = ld_value;
         WD_LINK: begin
            wdata_d = pc + PC_STEP;
            waddr_d = LINK_ADDR;
         end
         default: wdata_d = alu_rslt[XLEN-1:0];
      endcase
   end

   // The zero test uses the final address, so a link write is never
   // suppressed by rdst_in = 0.
   assign rf_we_d   = rfwr_in & ~mdiv_in & (waddr_d != '0) & (wd_sel != WD_RSVD);
   assign hilo_we_d = mdiv_in & HILO_ON;

   logic [31:0] retire_q;
   assign retire_cnt = retire_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   // NOTE: every flop here, data included, is reset so outputs are known zero after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_valid <= 1'b0;
         rf_we    <= 1'b0;
         hilo_we  <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         hi_wdata <= '0;
         lo_wdata <= '0;
         retire_q <= '0;
      end else if (flush) begin
         // Data fields hold; only the qualifiers drop.
         wb_valid <= 1'b0;
         rf_we    <= 1'b0;
         hilo_we  <= 1'b0;
      end else if (!stall) begin
         wb_valid <= in_valid;
         rf_we    <= in_valid & rf_we_d;
         hilo_we  <= in_valid & hilo_we_d;
         rf_waddr <= waddr_d;
         rf_wdata <= wdata_d;
         hi_wdata <= alu_rslt[2*XLEN-1:XLEN];
         lo_wdata <= alu_rslt[XLEN-1:0];
         if (in_valid) begin
            retire_q <= retire_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Directed bench for writeback_unit with default parameters. A table of
// single-cycle vectors covers the writeback source and load extraction
// cases; hand-written sequences cover reset, stall, flush and counter wrap.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        stall;
   logic        flush;
   logic [63:0] alu_rslt;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_off;
   logic [2:0]  ld_mode;
   logic [31:0] pc;
   logic [1:0]  wd_sel;
   logic [4:0]  rdst_in;
   logic        rfwr_in;
   logic        mdiv_in;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        hilo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;
   logic        wb_valid;
   logic [31:0] retire_cnt;

   writeback_unit dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .stall      (stall),
      .flush      (flush),
      .alu_rslt   (alu_rslt),
      .mem_rdata  (mem_rdata),
      .mem_off    (mem_off),
      .ld_mode    (ld_mode),
      .pc         (pc),
      .wd_sel     (wd_sel),
      .rdst_in    (rdst_in),
      .rfwr_in    (rfwr_in),
      .mdiv_in    (mdiv_in),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .hilo_we    (hilo_we),
      .hi_wdata   (hi_wdata),
      .lo_wdata   (lo_wdata),
      .wb_valid   (wb_valid),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        in_valid;
      logic [63:0] alu_rslt;
      logic [31:0] mem_rdata;
      logic [1:0]  mem_off;
      logic [2:0]  ld_mode;
      logic [31:0] pc;
      logic [1:0]  wd_sel;
      logic [4:0]  rdst;
      logic        rfwr;
      logic        mdiv;
      logic        e_valid;
      logic        e_rf_we;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
      logic        e_hilo_we;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_cnt  = 32'd0;
   vec_t        vecs[$];

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid  = v.in_valid;
      alu_rslt  = v.alu_rslt;
      mem_rdata = v.mem_rdata;
      mem_off   = v.mem_off;
      ld_mode   = v.ld_mode;
      pc        = v.pc;
      wd_sel    = v.wd_sel;
      rdst_in   = v.rdst;
      rfwr_in   = v.rfwr;
      mdiv_in   = v.mdiv;
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(string name, logic iv, logic [63:0] alu, logic [31:0] mrd,
                               logic [1:0] off, logic [2:0] ldm, logic [31:0] pcv,
                               logic [1:0] wsel, logic [4:0] rd, logic rfw, logic md,
                               logic ev, logic ewe, logic [4:0] ewa, logic [31:0] ewd,
                               logic ehw, logic [31:0] ehi, logic [31:0] elo);
      vec_t v;
      v.name = name; v.in_valid = iv; v.alu_rslt = alu; v.mem_rdata = mrd;
      v.mem_off = off; v.ld_mode = ldm; v.pc = pcv; v.wd_sel = wsel;
      v.rdst = rd; v.rfwr = rfw; v.mdiv = md;
      v.e_valid = ev; v.e_rf_we = ewe; v.e_waddr = ewa; v.e_wdata = ewd;
      v.e_hilo_we = ehw; v.e_hi = ehi; v.e_lo = elo;
      return v;
   endfunction

   task automatic check_vec(input vec_t v);
      check({v.name, ".wb_valid"}, 64'(wb_valid), 64'(v.e_valid));
      check({v.name, ".rf_we"},    64'(rf_we),    64'(v.e_rf_we));
      check({v.name, ".hilo_we"},  64'(hilo_we),  64'(v.e_hilo_we));
      check({v.name, ".retire"},   64'(retire_cnt), 64'(exp_cnt));
      if (v.e_rf_we) begin
         check({v.name, ".waddr"}, 64'(rf_waddr), 64'(v.e_waddr));
         check({v.name, ".wdata"}, 64'(rf_wdata), 64'(v.e_wdata));
      end
      if (v.e_hilo_we) begin
         check({v.name, ".hi"}, 64'(hi_wdata), 64'(v.e_hi));
         check({v.name, ".lo"}, 64'(lo_wdata), 64'(v.e_lo));
      end
   endtask

   localparam logic [31:0] MW = 32'h80FF_7F01;

   initial begin
      vec_t v;
      vec_t hold_v;

      //           name        iv alu                     mem off ld    pc            ws    rd  rfw md  ev we wa  wdata          hw hi            lo
      vecs.push_back(mk("alu",   1, 64'h0000_0000_1234_5678, 0,  0, 3'd0, 32'h0,        2'b00, 7,  1, 0,  1, 1, 7,  32'h1234_5678, 0, 0, 0));
      vecs.push_back(mk("lb_o3", 1, 64'h0,                   MW, 3, 3'd3, 32'h0,        2'b01, 3,  1, 0,  1, 1, 3,  32'hFFFF_FF80, 0, 0, 0));
      vecs.push_back(mk("lbu_o3",1, 64'h0,                   MW, 3, 3'd4, 32'h0,        2'b01, 3,  1, 0,  1, 1, 3,  32'h0000_0080, 0, 0, 0));
      vecs.push_back(mk("lh_o2", 1, 64'h0,                   MW, 2, 3'd1, 32'h0,        2'b01, 6,  1, 0,  1, 1, 6,  32'hFFFF_80FF, 0, 0, 0));
      vecs.push_back(mk("lh_o3", 1, 64'h0,                   MW, 3, 3'd1, 32'h0,        2'b01, 6,  1, 0,  1, 1, 6,  32'hFFFF_80FF, 0, 0, 0));
      vecs.push_back(mk("lhu_o0",1, 64'h0,                   MW, 0, 3'd2, 32'h0,        2'b01, 8,  1, 0,  1, 1, 8,  32'h0000_7F01, 0, 0, 0));
      vecs.push_back(mk("lb_o1", 1, 64'h0,                   MW, 1, 3'd3, 32'h0,        2'b01, 9,  1, 0,  1, 1, 9,  32'h0000_007F, 0, 0, 0));
      vecs.push_back(mk("lw",    1, 64'h0,                   MW, 2, 3'd0, 32'h0,        2'b01, 10, 1, 0,  1, 1, 10, 32'h80FF_7F01, 0, 0, 0));
      vecs.push_back(mk("lw_m7", 1, 64'h0,                   MW, 1, 3'd7, 32'h0,        2'b01, 11, 1, 0,  1, 1, 11, 32'h80FF_7F01, 0, 0, 0));
      vecs.push_back(mk("link",  1, 64'h0,                   0,  0, 3'd0, 32'h0000_3FFC,2'b10, 4,  1, 0,  1, 1, 31, 32'h0000_4000, 0, 0, 0));
      vecs.push_back(mk("linkwr",1, 64'h0,                   0,  0, 3'd0, 32'hFFFF_FFFC,2'b10, 0,  1, 0,  1, 1, 31, 32'h0000_0000, 0, 0, 0));
      vecs.push_back(mk("hilo",  1, 64'hDEAD_BEEF_0123_4567, 0,  0, 3'd0, 32'h0,        2'b00, 5,  1, 1,  1, 0, 0,  0,             1, 32'hDEAD_BEEF, 32'h0123_4567));
      vecs.push_back(mk("r0",    1, 64'h0000_0000_5555_5555, 0,  0, 3'd0, 32'h0,        2'b00, 0,  1, 0,  1, 0, 0,  0,             0, 0, 0));
      vecs.push_back(mk("rsvd",  1, 64'h0000_0000_5555_5555, 0,  0, 3'd0, 32'h0,        2'b11, 9,  1, 0,  1, 0, 0,  0,             0, 0, 0));
      vecs.push_back(mk("nowr",  1, 64'h0000_0000_5555_5555, 0,  0, 3'd0, 32'h0,        2'b00, 9,  0, 0,  1, 0, 0,  0,             0, 0, 0));
      vecs.push_back(mk("bubble",0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  0, 3'd0, 32'h0,        2'b00, 9,  1, 1,  0, 0, 0,  0,             0, 0, 0));
      vecs.push_back(mk("alu2",  1, 64'h0000_0000_CAFE_F00D, 0,  0, 3'd0, 32'h0,        2'b00, 30, 1, 0,  1, 1, 30, 32'hCAFE_F00D, 0, 0, 0));

      // Reset dominates stall, flush and a presented instruction.
      rst = 1'b0; stall = 1'b1; flush = 1'b1;
      drive(vecs[0]);
      tick();
      tick();
      check("rst.wb_valid", 64'(wb_valid), 64'd0);
      check("rst.rf_we",    64'(rf_we),    64'd0);
      check("rst.hilo_we",  64'(hilo_we),  64'd0);
      check("rst.waddr",    64'(rf_waddr), 64'd0);
      check("rst.wdata",    64'(rf_wdata), 64'd0);
      check("rst.hi",       64'(hi_wdata), 64'd0);
      check("rst.lo",       64'(lo_wdata), 64'd0);
      check("rst.retire",   64'(retire_cnt), 64'd0);

      // First edge with rst=1 captures.
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      foreach (vecs[i]) begin
         drive(vecs[i]);
         tick();
         if (vecs[i].in_valid) exp_cnt = exp_cnt + 32'd1;
         check_vec(vecs[i]);
      end

      // Stall for 3 cycles: output register and counter frozen even though a
      // different valid instruction is presented.
      hold_v = mk("hold", 1, 64'h0000_0000_AAAA_5555, 0, 0, 3'd0, 32'h0, 2'b00, 12, 1, 0,
                  1, 1, 12, 32'hAAAA_5555, 0, 0, 0);
      drive(hold_v);
      tick();
      exp_cnt = exp_cnt + 32'd1;
      check_vec(hold_v);
      v = mk("after_stall", 1, 64'h0000_0000_0000_0000, 0, 0, 3'd0, 32'h0, 2'b00, 13, 1, 0,
             1, 1, 13, 32'h0000_0000, 0, 0, 0);
      drive(v);
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         hold_v.name = $sformatf("stall%0d", c);
         check_vec(hold_v);
      end
      stall = 1'b0;
      tick();
      exp_cnt = exp_cnt + 32'd1;
      check_vec(v);

      // Stall and flush in the same cycle: flush wins, nothing retires.
      v = mk("stall_flush", 1, 64'h0000_0000_1111_1111, 0, 0, 3'd0, 32'h0, 2'b00, 14, 1, 0,
             0, 0, 0, 0, 0, 0, 0);
      drive(v);
      stall = 1'b1; flush = 1'b1;
      tick();
      check_vec(v);

      // Flush alone discards the presented instruction, HI/LO included.
      v = mk("flush", 1, 64'h1111_1111_2222_2222, 0, 0, 3'd0, 32'h0, 2'b00, 15, 0, 1,
             0, 0, 0, 0, 0, 0, 0);
      drive(v);
      stall = 1'b0; flush = 1'b1;
      tick();
      check_vec(v);
      flush = 1'b0;

      // Counter wrap: preload all-ones, then one retirement returns it to 0.
      force dut.retire_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_q;
      #1;
      exp_cnt = 32'hFFFF_FFFF;
      check("wrap.preload", 64'(retire_cnt), 64'(exp_cnt));
      v = mk("wrap", 1, 64'h0000_0000_0BAD_F00D, 0, 0, 3'd0, 32'h0, 2'b00, 16, 1, 0,
             1, 1, 16, 32'h0BAD_F00D, 0, 0, 0);
      drive(v);
      @(negedge clk);
      tick();
      exp_cnt = 32'd0;
      check_vec(v);

      // Reset mid-stream while wb_valid=1 clears everything on the next edge.
      v = mk("mid_hilo", 1, 64'h7777_7777_8888_8888, 0, 0, 3'd0, 32'h0, 2'b00, 17, 0, 1,
             1, 0, 0, 0, 1, 32'h7777_7777, 32'h8888_8888);
      drive(v);
      tick();
      exp_cnt = exp_cnt + 32'd1;
      check_vec(v);
      rst = 1'b0;
      tick();
      check("midrst.wb_valid", 64'(wb_valid), 64'd0);
      check("midrst.rf_we",    64'(rf_we),    64'd0);
      check("midrst.hilo_we",  64'(hilo_we),  64'd0);
      check("midrst.waddr",    64'(rf_waddr), 64'd0);
      check("midrst.wdata",    64'(rf_wdata), 64'd0);
      check("midrst.hi",       64'(hi_wdata), 64'd0);
      check("midrst.lo",       64'(lo_wdata), 64'd0);
      check("midrst.retire",   64'(retire_cnt), 64'd0);
      exp_cnt = 32'd0;

      // First edge after reset release captures the presented instruction.
      rst = 1'b1;
      tick();
      exp_cnt = exp_cnt + 32'd1;
      v.name = "post_rst";
      check_vec(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
